// File: rtl/mips_cpu_multdiv.sv
// HI/LO multiply-divide unit: 32-step shift-add multiplier and
// restoring divider sharing one 2*WIDTH working register.
module mips_cpu_multdiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [2:0] OP_DIVU  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_MULT  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MFHI  = 3'b110;
    localparam logic [5:0] LAST     = 6'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV
    } state_e;

    state_e             state_q;
    logic [5:0]         cnt_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               busy_q, done_q;
    logic [WIDTH-1:0]   opnd_q;
    logic [2*WIDTH-1:0] prod_q;
    logic               neg_q, rneg_q;

    logic               is_sgn;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     add_sum;
    logic [2*WIDTH-1:0] mul_step, mul_fin;
    logic [WIDTH:0]     div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] div_step;
    logic [WIDTH-1:0]   quo_fin, rem_fin;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x,
                                             input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    assign is_sgn = (op == OP_MULT) || (op == OP_DIV);

    // prod_q holds {acc, multiplier} for MUL and {rem, dividend} for DIV
    always_comb begin
        addend    = prod_q[0] ? opnd_q : {WIDTH{1'b0}};
        add_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        mul_step  = {add_sum, prod_q[WIDTH-1:1]};
        mul_fin   = neg_q ? -mul_step : mul_step;
        div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_rem   = div_shift[WIDTH-1:0] - opnd_q;
        div_step  = {div_ge ? div_rem : div_shift[WIDTH-1:0],
                     prod_q[WIDTH-2:0], div_ge};
        quo_fin   = neg_q ? -div_step[WIDTH-1:0] : div_step[WIDTH-1:0];
        rem_fin   = rneg_q ? -div_step[2*WIDTH-1:WIDTH]
                           : div_step[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            opnd_q  <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        unique case (op)
                            OP_MULT, OP_MULTU: begin
                                state_q <= S_MUL;
                                busy_q  <= 1'b1;
                                cnt_q   <= '0;
                                opnd_q  <= mag(a, is_sgn);
                                prod_q  <= {{WIDTH{1'b0}}, mag(b, is_sgn)};
                                neg_q   <= is_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                                rneg_q  <= 1'b0;
                            end
                            OP_DIV, OP_DIVU: begin
                                state_q <= S_DIV;
                                busy_q  <= 1'b1;
                                cnt_q   <= '0;
                                opnd_q  <= mag(b, is_sgn);
                                prod_q  <= {{WIDTH{1'b0}}, mag(a, is_sgn)};
                                neg_q   <= is_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                                rneg_q  <= is_sgn & a[WIDTH-1];
                            end
                            OP_MTHI: hi_q <= a;
                            OP_MTLO: lo_q <= a;
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    cnt_q  <= cnt_q + 6'd1;
                    prod_q <= mul_step;
                    if (cnt_q == LAST) begin
                        {hi_q, lo_q} <= mul_fin;
                        state_q      <= S_IDLE;
                        busy_q       <= 1'b0;
                        done_q       <= 1'b1;
                    end
                end
                S_DIV: begin
                    cnt_q  <= cnt_q + 6'd1;
                    prod_q <= div_step;
                    if (cnt_q == LAST) begin
                        hi_q    <= rem_fin;
                        lo_q    <= quo_fin;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign result = (op == OP_MFHI) ? hi_q : lo_q;

endmodule
